// File: rtl/axi_traffic_checker.sv
// AXI4 traffic checker: writes a deterministic INCR burst pattern, reads it back and
// compares every beat, reporting done/pass/error_count.
//
// state   | meaning
// IDLE    | waiting for start after reset
// WR_ADDR | presenting AW for burst b
// WR_DATA | streaming BURST_LEN write beats
// WR_RESP | waiting for B, checking bresp/bid
// RD_ADDR | presenting AR for burst b
// RD_DATA | receiving and checking read beats
// DONE    | results held until start or reset
module axi_traffic_checker #(
   parameter int                    DATA_WIDTH = 256,
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    ID_WIDTH   = 7,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    BURST_LEN  = 8,
   parameter int                    NUM_BURSTS = 4,
   parameter logic [31:0]           SEED       = 32'h0
) (
   input  logic                    axi_clk_in_clk,
   input  logic                    axi_reset_in_reset,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [15:0]             error_count,
   output logic [ID_WIDTH-1:0]     awid,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [ID_WIDTH-1:0]     bid,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   output logic [ID_WIDTH-1:0]     arid,
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [7:0]              arlen,
   output logic [2:0]              arsize,
   output logic [1:0]              arburst,
   output logic                    arvalid,
   input  logic                    arready,
   input  logic [ID_WIDTH-1:0]     rid,
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rlast,
   input  logic                    rvalid,
   output logic                    rready
);

   localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
   localparam logic [15:0]           LAST_BURST  = 16'(NUM_BURSTS - 1);
   localparam logic [2:0]            SIZE        = 3'($clog2(DATA_WIDTH / 8));
   localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
   localparam logic [31:0]           BURST_WORDS = 32'(BURST_LEN);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [15:0]             b_q, b_d;
   logic [7:0]              j_q, j_d;
   logic                    over_q, over_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [31:0]             bword_q, bword_d;
   logic [15:0]             err_q, err_d;
   logic                    err_hit;
   logic [ID_WIDTH-1:0]     cur_id;
   logic [DATA_WIDTH-1:0]   exp_data;
   logic                    last_beat;

   assign cur_id    = ID_WIDTH'(b_q);
   assign exp_data  = {(DATA_WIDTH / 32){SEED + bword_q + 32'(j_q)}};
   assign last_beat = (j_q == LAST_BEAT);

   always_ff @(posedge axi_clk_in_clk) begin
      if (axi_reset_in_reset) begin
         state_q <= IDLE;
         b_q     <= '0;
         j_q     <= '0;
         over_q  <= 1'b0;
         addr_q  <= BASE_ADDR;
         bword_q <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         j_q     <= j_d;
         over_q  <= over_d;
         addr_q  <= addr_d;
         bword_q <= bword_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      j_d     = j_q;
      over_d  = over_q;
      addr_d  = addr_q;
      bword_d = bword_q;
      err_d   = err_q;
      err_hit = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = WR_ADDR;
               b_d     = '0;
               j_d     = '0;
               over_d  = 1'b0;
               addr_d  = BASE_ADDR;
               bword_d = '0;
               err_d   = '0;
            end
         end
         WR_ADDR: begin
            awvalid = 1'b1;
            if (awready) state_d = WR_DATA;
         end
         WR_DATA: begin
            wvalid = 1'b1;
            if (wready) begin
               if (last_beat) begin
                  j_d     = '0;
                  state_d = WR_RESP;
               end else begin
                  j_d = j_q + 8'd1;
               end
            end
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               err_hit = (bresp != 2'b00) || (bid != cur_id);
               if (b_q == LAST_BURST) begin
                  b_d     = '0;
                  addr_d  = BASE_ADDR;
                  bword_d = '0;
                  state_d = RD_ADDR;
               end else begin
                  b_d     = b_q + 16'd1;
                  addr_d  = addr_q + BURST_BYTES;
                  bword_d = bword_q + BURST_WORDS;
                  state_d = WR_ADDR;
               end
            end
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               // Once past the last expected beat every extra beat is an error on its own.
               err_hit = over_q || (rdata != exp_data) || (rresp != 2'b00) ||
                         (rid != cur_id) || (rlast != last_beat);
               if (rlast) begin
                  j_d    = '0;
                  over_d = 1'b0;
                  if (b_q == LAST_BURST) begin
                     state_d = DONE;
                  end else begin
                     b_d     = b_q + 16'd1;
                     addr_d  = addr_q + BURST_BYTES;
                     bword_d = bword_q + BURST_WORDS;
                     state_d = RD_ADDR;
                  end
               end else if (last_beat) begin
                  over_d = 1'b1;
               end else begin
                  j_d = j_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (err_hit && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
   end

   assign awid        = cur_id;
   assign awaddr      = addr_q;
   assign awlen       = LAST_BEAT;
   assign awsize      = SIZE;
   assign awburst     = 2'b01;
   assign wdata       = exp_data;
   assign wstrb       = '1;
   assign wlast       = wvalid && last_beat;
   assign arid        = cur_id;
   assign araddr      = addr_q;
   assign arlen       = LAST_BEAT;
   assign arsize      = SIZE;
   assign arburst     = 2'b01;
   assign busy        = (state_q != IDLE) && (state_q != DONE);
   assign done        = (state_q == DONE);
   assign pass        = done && (err_q == 16'h0000);
   assign error_count = err_q;

endmodule

// File: doc/axi_traffic_checker.md
Name: axi_traffic_checker

Overview:
- Synthesizable AXI4 master that writes a deterministic pattern of INCR bursts into HBM through a NoC initiator, reads the pattern back and checks every beat.
- Sits directly upstream of a NoC initiator AXI slave port, in the slot the simulation BFM master occupies.
- Gives hardware self-test without a BFM. Results go out on done/pass/error_count.

Parameters:
DATA_WIDTH, 256, AXI data width in bits; multiple of 32
ADDR_WIDTH, 64, AXI address width
ID_WIDTH, 7, AXI ID width
BASE_ADDR, 64'h0, byte address of the first burst; aligned to DATA_WIDTH/8
BURST_LEN, 8, beats per burst, 1..256
NUM_BURSTS, 4, bursts per run, 1..65535
SEED, 32'h0, pattern offset

Ports:
axi_clk_in_clk  in  1  clock for all logic
axi_reset_in_reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that begins a run
busy  out  1  high from the cycle after an accepted start until done
done  out  1  sticky high when the run completes; cleared by start
pass  out  1  valid when done; 1 if error_count==0
error_count  out  16  saturating count of failed checks
awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AXI write address
awready  in  1
wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data
wready  in  1
bid/bresp/bvalid  in  ID_WIDTH/2/1
bready  out  1
arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/DATA_WIDTH/2/1/1
rready  out  1

Behaviour:
Reset values and constant fields:
- On reset, all valid and ready outputs, busy, done, pass and error_count are 0. FSM goes to IDLE. Burst and beat counters go to 0.
- Reset wins over every other event, mid-run included. Outputs drop on that edge; the fabric is reset with this block.
- awsize/arsize = log2(DATA_WIDTH/8). awburst/arburst = 2'b01. awlen/arlen = BURST_LEN-1. wstrb = all ones.

Addressing and pattern (b = burst index, j = beat index):
- Burst b address = BASE_ADDR + b*BURST_LEN*(DATA_WIDTH/8). Arithmetic is modulo 2^ADDR_WIDTH.
- ID for burst b = b[ID_WIDTH-1:0] on both AW and AR.
- Beat word k = b*BURST_LEN + j. Data = (SEED + k) mod 2^32, replicated DATA_WIDTH/32 times.

FSM states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE:
- IDLE or DONE + start: clear error_count and done, set b=0, go to WR_ADDR. start in any other state is ignored.
- WR_ADDR: awvalid=1 with stable fields until awready. Go to WR_DATA.
- WR_DATA: wvalid=1. Beat j advances on wvalid&wready. wlast=1 on j==BURST_LEN-1. After the last beat handshake, go to WR_RESP. W is never issued before its AW handshake.
- WR_RESP: bready=1. On bvalid, an error is counted if bresp!=0 or bid != expected ID.
  - If b<NUM_BURSTS-1: b++, go to WR_ADDR.
  - Otherwise b=0, go to RD_ADDR.
- RD_ADDR: arvalid=1 until arready. Go to RD_DATA.
- RD_DATA: rready=1. Each rvalid beat is one check; a beat with any of the following mismatches counts one error:
  - rdata vs pattern
  - rresp!=0
  - rid vs expected ID
  - rlast vs (j==BURST_LEN-1)
- RD_DATA burst end:
  - Burst ends on a beat with rlast=1, early rlast included. Remaining expected beats are not counted.
  - Beats after j==BURST_LEN-1 without rlast are discarded, one error each, until rlast.
  - At burst end: if b<NUM_BURSTS-1, b++ and go to RD_ADDR; otherwise go to DONE.
- DONE: done=1, busy=0, pass=(error_count==0). Held until start or reset.

Handshake and counter rules:
- One outstanding transaction at a time. At most one valid is asserted per cycle.
- Valid is asserted the cycle after the state is entered and is never withdrawn before ready.
- ready may already be high when valid rises; the transfer then completes in that cycle.
- error_count saturates at 16'hFFFF.
- Latency: start to first awvalid = 1 cycle.
- busy = state is not IDLE and not DONE.

Test Plan:
- Zero-wait AXI slave memory, defaults -> 4 write bursts at 0x0, 0x100, 0x200, 0x300 with awlen=7, awsize=5; readback matches; done=1, pass=1, error_count=0.
- Random awready/wready/arready/rvalid stalls (0-5 cycles), SEED=32'h1000 -> same addresses; word 0 = 0x00001000 replicated, word 31 = 0x0000101F replicated; pass=1; no valid drops before ready.
- Slave corrupts bit 0 of word 10 on read -> error_count=1, pass=0.
- Slave returns bresp=2'b10 on burst 2 and rlast one beat early on read burst 1 -> error_count=2; done still reached; next burst at 0x200 issued normally.
- Reset asserted in WR_DATA beat 3 -> next cycle all valids=0, busy=0; a new start repeats the full run from 0x0 and passes.
- start pulsed while busy, then again in DONE -> first ignored; second clears done and error_count and restarts at awaddr=BASE_ADDR with awid=0.
